clock_mode_ctrl: RTL and testbench

Parameterised mode controller for the digital clock, the successor to the two-switch mode selector. It cycles through NUM_MODES operating modes from a debounced push button, returns to mode 0 from an exit button, and optionally falls back to mode 0 after a period of inactivity. It drives the one-hot mode LEDs and a mode index that downstream time-keeping, time-set and alarm logic decode.

---
 rtl/clock_mode_pkg.sv | 18 +
 rtl/key_debounce.sv | 57 +++++
 rtl/clock_mode_ctrl.sv | 114 +++++++++++
 tb/tb_clock_mode_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_mode_pkg.sv
// Shared constants and helpers for the digital clock mode controller.
package clock_mode_pkg;

    // Operating mode indices decoded by the time-keeping, time-set and alarm logic
    localparam int MODE_RUN        = 0;
    localparam int MODE_SET_TIME   = 1;
    localparam int MODE_SHOW_ALARM = 2;
    localparam int MODE_SET_ALARM  = 3;

    // 20 ms of key stability at a 50 MHz system clock
    localparam int DEFAULT_DEBOUNCE_CYC = 1_000_000;

    // One-hot vector with only bit idx set; callers cast it down to their mode count
    function automatic logic [31:0] mode_onehot(input logic [31:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw push-button conditioning: 2-FF synchroniser, debounce counter and a
// single-cycle press pulse on each accepted 0->1 change of the key level.
module key_debounce
    import clock_mode_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic key_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             press_r;
    logic [CNT_W-1:0] cnt_r;

    // Bring the asynchronous key into the clock domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= key_raw;
            sync2_r <= sync1_r;
        end
    end

    // Accept a new level only after DEBOUNCE_CYC consecutive mismatching cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (sync2_r != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_r <= sync2_r;
                press_r <= sync2_r;
                cnt_r   <= {CNT_W{1'b0}};
            end else begin
                press_r <= 1'b0;
                cnt_r   <= cnt_r + CNT_W'(1);
            end
        end else begin
            press_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end
    end

    assign key_press = press_r;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Digital clock mode controller: steps through NUM_MODES modes on the "next"
// key, returns to mode 0 on the "exit" key and, when built with the
// MODE_TIMEOUT_EN macro, falls back to mode 0 after TIMEOUT_SEC seconds
// without key activity. Without the macro tick_1hz is ignored.
module clock_mode_ctrl
    import clock_mode_pkg::*;
#(
    parameter int NUM_MODES    = 4,
    parameter int MODE_W       = $clog2(NUM_MODES),
    parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
    parameter int TIMEOUT_SEC  = 30
) (
    input  logic                 clk_50M,
    input  logic                 rst_n,
    input  logic                 key_next,
    input  logic                 key_exit,
    input  logic                 tick_1hz,
    output logic [MODE_W-1:0]    state_mode,
    output logic [NUM_MODES-1:0] led_mode,
    output logic                 mode_changed
);

    localparam logic [MODE_W-1:0] MODE_ZERO = MODE_W'(MODE_RUN);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

    logic                 next_press_s;
    logic                 exit_press_s;
    logic                 timeout_s;
    logic [MODE_W-1:0]    mode_next_s;
    logic [MODE_W-1:0]    mode_r;
    logic [NUM_MODES-1:0] led_r;
    logic                 changed_r;

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_next (
        .clk       (clk_50M),
        .rst_n     (rst_n),
        .key_raw   (key_next),
        .key_press (next_press_s)
    );

    key_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_key_exit (
        .clk       (clk_50M),
        .rst_n     (rst_n),
        .key_raw   (key_exit),
        .key_press (exit_press_s)
    );

    // Next mode: exit beats next, next beats the inactivity timeout
    always_comb begin
        mode_next_s = mode_r;
        if (exit_press_s) begin
            mode_next_s = MODE_ZERO;
        end else if (next_press_s) begin
            if (mode_r == MODE_LAST) begin
                mode_next_s = MODE_ZERO;
            end else begin
                mode_next_s = mode_r + MODE_W'(1);
            end
        end else if (timeout_s) begin
            mode_next_s = MODE_ZERO;
        end else begin
            mode_next_s = mode_r;
        end
    end

    // Mode index, LEDs and change strobe all load from the same next-state value
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            mode_r    <= MODE_ZERO;
            led_r     <= {{(NUM_MODES-1){1'b0}}, 1'b1};
            changed_r <= 1'b0;
        end else begin
            mode_r    <= mode_next_s;
            led_r     <= NUM_MODES'(mode_onehot(32'(mode_next_s)));
            changed_r <= (mode_next_s != mode_r);
        end
    end

`ifdef MODE_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_SEC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_SEC - 1);

    logic [TMR_W-1:0] timer_r;

    // Timeout fires on the tick that would bring the count to TIMEOUT_SEC
    assign timeout_s = tick_1hz && (mode_r != MODE_ZERO) && (timer_r == TMR_LAST);

    // Seconds of inactivity outside mode 0; any press or mode change restarts it
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (next_press_s || exit_press_s || (mode_r == MODE_ZERO) ||
                     (mode_next_s != mode_r)) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (tick_1hz) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end
`else
    // No auto-return in this build; the tick is deliberately discarded
    assign timeout_s = tick_1hz & 1'b0;
`endif

    assign state_mode   = mode_r;
    assign led_mode     = led_r;
    assign mode_changed = changed_r;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl with a cycle-level reference model
// built from the key-stability, priority and timeout rules.
module tb_clock_mode_ctrl;

    localparam int NM = 4;
    localparam int DB = 4;
    localparam int TS = 3;
`ifdef MODE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk_50M  = 1'b0;
    logic          rst_n    = 1'b0;
    logic          key_next = 1'b0;
    logic          key_exit = 1'b0;
    logic          tick_1hz = 1'b0;
    logic [1:0]    state_mode;
    logic [NM-1:0] led_mode;
    logic          mode_changed;

    int checks  = 0;
    int errors  = 0;
    int chg_cnt = 0;

    clock_mode_ctrl #(
        .NUM_MODES    (NM),
        .MODE_W       (2),
        .DEBOUNCE_CYC (DB),
        .TIMEOUT_SEC  (TS)
    ) dut (
        .clk_50M      (clk_50M),
        .rst_n        (rst_n),
        .key_next     (key_next),
        .key_exit     (key_exit),
        .tick_1hz     (tick_1hz),
        .state_mode   (state_mode),
        .led_mode     (led_mode),
        .mode_changed (mode_changed)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: raw-sample history per key (index 0 = next, 1 = exit)
    bit hist [2][DB+2];
    bit lvl  [2];
    bit pend [2];
    int m_mode;
    int m_timer;
    bit m_changed;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < DB + 2; j++) hist[k][j] = 1'b0;
            lvl[k]  = 1'b0;
            pend[k] = 1'b0;
        end
        m_mode    = 0;
        m_timer   = 0;
        m_changed = 1'b0;
    endtask

    // One clock edge: apply presses accepted on the previous edge, then debounce
    task automatic model_edge(input bit kn, input bit ke, input bit tk);
        int  nm;
        bit  all_diff;
        bit  raw [2];
        raw[0] = kn;
        raw[1] = ke;
        if (pend[1])                                            nm = 0;
        else if (pend[0])                                       nm = (m_mode + 1) % NM;
        else if (TO_EN && tk && m_mode != 0 && m_timer + 1 == TS) nm = 0;
        else                                                    nm = m_mode;
        if (pend[0] || pend[1] || nm != m_mode || m_mode == 0) m_timer = 0;
        else if (tk)                                           m_timer++;
        m_changed = (nm != m_mode);
        m_mode    = nm;
        for (int k = 0; k < 2; k++) begin
            for (int j = DB + 1; j > 0; j--) hist[k][j] = hist[k][j-1];
            hist[k][0] = raw[k];
            // the synchronised value seen at this edge is the raw sample two edges old
            all_diff = 1'b1;
            for (int j = 2; j <= DB + 1; j++) if (hist[k][j] == lvl[k]) all_diff = 1'b0;
            pend[k] = 1'b0;
            if (all_diff) begin
                lvl[k]  = ~lvl[k];
                pend[k] = lvl[k];
            end
        end
    endtask

    task automatic step(input bit kn, input bit ke, input bit tk);
        key_next = kn;
        key_exit = ke;
        tick_1hz = tk;
        @(posedge clk_50M);
        model_edge(kn, ke, tk);
        #1;
        check("mode", state_mode, m_mode);
        check("led", led_mode, 32'd1 << m_mode);
        check("chg", mode_changed, m_changed);
        if (mode_changed === 1'b1) chg_cnt++;
    endtask

    task automatic press(input bit kn, input bit ke);
        for (int c = 0; c < 20; c++) step(c < 10 ? kn : 1'b0, c < 10 ? ke : 1'b0, 1'b0);
    endtask

    task automatic goto_mode(input int target);
        for (int g = 0; g < 8 && m_mode != target; g++) press(1'b1, 1'b0);
    endtask

    initial begin
        int lat;
        bit prev_tk;
        bit kn;
        bit ke;
        bit tk;
        int run_n;
        int run_e;

        model_reset();
        #25;
        check("rst_mode", state_mode, 0);
        check("rst_led", led_mode, 4'b0001);
        check("rst_chg", mode_changed, 0);
        #10 rst_n = 1'b1;

        // Four clean presses with latency measurement from the raw edge
        for (int i = 0; i < 4; i++) begin
            lat = -1;
            for (int c = 0; c < 20; c++) begin
                step(c < 10, 1'b0, 1'b0);
                if (mode_changed === 1'b1 && lat < 0) lat = c + 1;
            end
            check("press_latency", lat, 7);
            check("press_mode", state_mode, (i + 1) % NM);
            check("press_led", led_mode, 32'd1 << ((i + 1) % NM));
        end

        // Bouncing key, then a clean hold: one advance
        chg_cnt = 0;
        for (int b = 0; b < 3; b++) begin
            repeat (3) step(1'b1, 1'b0, 1'b0);
            repeat (2) step(1'b0, 1'b0, 1'b0);
        end
        repeat (10) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        check("bounce_adv", chg_cnt, 1);
        check("bounce_mode", state_mode, 1);

        // Long hold: still a single advance
        chg_cnt = 0;
        repeat (100) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        check("hold_adv", chg_cnt, 1);
        check("hold_mode", state_mode, 2);

        // Inactivity timeout from mode 2
        chg_cnt = 0;
        for (int t = 0; t < 3; t++) begin
            step(1'b0, 1'b0, 1'b1);
            repeat (4) step(1'b0, 1'b0, 1'b0);
        end
        check("timeout_mode", state_mode, TO_EN ? 0 : 2);
        check("timeout_chg", chg_cnt, TO_EN ? 1 : 0);

        // Press between tick 2 and tick 3 restarts the timer
        goto_mode(2);
        step(1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0, 1'b0);
        check("restart_mode", state_mode, 3);
        for (int t = 0; t < 2; t++) begin
            step(1'b0, 1'b0, 1'b1);
            repeat (4) step(1'b0, 1'b0, 1'b0);
        end
        check("restart_timeout", state_mode, TO_EN ? 0 : 3);

        // Simultaneous next and exit in mode 1: exit wins
        goto_mode(1);
        press(1'b1, 1'b1);
        check("both_mode", state_mode, 0);

        // Exit in mode 0: no change, no pulse
        chg_cnt = 0;
        press(1'b0, 1'b1);
        check("exit0_chg", chg_cnt, 0);
        check("exit0_mode", state_mode, 0);

        // Ten ticks in mode 1
        goto_mode(1);
        for (int t = 0; t < 10; t++) begin
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
        end
        check("ticks_mode1", state_mode, TO_EN ? 0 : 1);

        // Asynchronous reset in mode 2 while a press is mid-debounce
        goto_mode(2);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        #5 rst_n = 1'b0;
        #1;
        check("arst_mode", state_mode, 0);
        check("arst_led", led_mode, 4'b0001);
        check("arst_chg", mode_changed, 0);
        model_reset();
        @(negedge clk_50M);
        rst_n = 1'b1;
        repeat (10) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        check("arst_fresh_press", state_mode, 1);

        // Randomised keys and ticks against the model
        prev_tk = 1'b0;
        kn = 1'b0;
        ke = 1'b0;
        run_n = 0;
        run_e = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run_n == 0) begin
                kn = ~kn;
                run_n = $urandom_range(1, 9);
            end
            if (run_e == 0) begin
                ke = ($urandom_range(0, 3) == 0) ? ~ke : 1'b0;
                run_e = $urandom_range(2, 14);
            end
            run_n--;
            run_e--;
            tk = !prev_tk && ($urandom_range(0, 5) == 0);
            prev_tk = tk;
            step(kn, ke, tk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
